// File: rtl/eth_pkg.sv
// eth_pkg: shared types and default frame/link constants for the Ethernet video path
package eth_pkg;
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, PAYLOAD, GAP} feeder_state_t;
  localparam int HDR_BYTES      = 2;
  localparam int BYTE_CYCLES    = 4;
  localparam int FRAME_WIDTH    = 320;
  localparam int FRAME_HEIGHT   = 240;
  localparam int FRAME_PIXELS   = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int PIXELS_PER_PKT = 1280;
  localparam int RD_LATENCY     = 2;
  localparam int IPG_CYCLES     = 96;
endpackage

// File: rtl/eth_pixel_feeder.sv
// eth_pixel_feeder: streams a stored frame as indexed, paced packets into the Ethernet packer
module eth_pixel_feeder #(
  parameter int FRAME_PIXELS   = eth_pkg::FRAME_PIXELS,
  parameter int PIXELS_PER_PKT = eth_pkg::PIXELS_PER_PKT,
  parameter int BYTE_CYCLES    = eth_pkg::BYTE_CYCLES,
  parameter int RD_LATENCY     = eth_pkg::RD_LATENCY,
  parameter int IPG_CYCLES     = eth_pkg::IPG_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_frame,
  output logic [$clog2(FRAME_PIXELS)-1:0] rd_addr,
  input  logic [7:0]                      rd_data,
  output logic                            axiov,
  output logic [7:0]                      pixel,
  output logic                            busy,
  output logic                            frame_done
);
  import eth_pkg::*;
  localparam int AW = $clog2(FRAME_PIXELS);
  localparam int PW = $clog2(FRAME_PIXELS + 1);
  localparam int SW = $clog2(BYTE_CYCLES);
  localparam int GW = $clog2(IPG_CYCLES + 1);
  localparam int CW = $clog2(PIXELS_PER_PKT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(BYTE_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_CAP  = SW'(RD_LATENCY);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IPG_CYCLES - 1);
  localparam logic [PW-1:0] PIX_END   = PW'(FRAME_PIXELS);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] TWO       = CW'(2);

  feeder_state_t   state;
  logic [SW-1:0]   slot;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   pay_cnt;
  logic [PW-1:0]   pix_addr;
  logic [15:0]     pkt_idx;
  logic [15:0]     pkt_next;
  logic [7:0]      hold;
  logic [7:0]      fetched;
  logic [31:0]     remaining;
  logic [CW-1:0]   pkt_len;
  logic            slot_end;

  // Next payload byte comes straight from the BRAM when its capture clock is the slot's last clock
  always_comb begin
    slot_end  = slot == SLOT_LAST;
    fetched   = (slot == SLOT_CAP) ? rd_data : hold;
    remaining = 32'(PIX_END - pix_addr);
    pkt_len   = (remaining < 32'(PIXELS_PER_PKT)) ? CW'(remaining) : CW'(PIXELS_PER_PKT);
    pkt_next  = pkt_idx + 16'd1;
  end

  // Packet sequencer: header bytes, prefetched payload one slot ahead, then the idle gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      slot       <= '0;
      gap_cnt    <= '0;
      pay_cnt    <= '0;
      pix_addr   <= '0;
      pkt_idx    <= '0;
      hold       <= '0;
      rd_addr    <= '0;
      axiov      <= 1'b0;
      pixel      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      slot       <= slot_end ? '0 : slot + 1'b1;
      if (slot == SLOT_CAP) hold <= rd_data;
      case (state)
        IDLE: if (start_frame && !frame_done) begin
          state    <= HDR_HI;
          busy     <= 1'b1;
          axiov    <= 1'b1;
          pixel    <= '0;
          pkt_idx  <= '0;
          pix_addr <= '0;
          slot     <= '0;
        end
        HDR_HI: if (slot_end) begin
          state    <= HDR_LO;
          pixel    <= pkt_idx[7:0];
          pay_cnt  <= pkt_len;
          rd_addr  <= AW'(pix_addr);
          pix_addr <= pix_addr + 1'b1;
        end
        HDR_LO: if (slot_end) begin
          state <= PAYLOAD;
          pixel <= fetched;
          if (pay_cnt > ONE) begin
            rd_addr  <= AW'(pix_addr);
            pix_addr <= pix_addr + 1'b1;
          end
        end
        PAYLOAD: if (slot_end) begin
          if (pay_cnt > ONE) begin
            pixel   <= fetched;
            pay_cnt <= pay_cnt - 1'b1;
            if (pay_cnt > TWO) begin
              rd_addr  <= AW'(pix_addr);
              pix_addr <= pix_addr + 1'b1;
            end
          end else begin
            state   <= GAP;
            axiov   <= 1'b0;
            pixel   <= '0;
            gap_cnt <= '0;
          end
        end
        GAP: if (gap_cnt == GAP_LAST) begin
          pkt_idx <= pkt_next;
          if (pix_addr == PIX_END) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            state <= HDR_HI;
            axiov <= 1'b1;
            pixel <= pkt_next[15:8];
            slot  <= '0;
          end
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_pixel_feeder.sv
// tb_eth_pixel_feeder: scoreboard bench for the packetised frame feeder
module tb_eth_pixel_feeder;
  localparam int FP  = 10;
  localparam int PPP = 4;
  localparam int BC  = 4;
  localparam int RDL = 2;
  localparam int IPG = 8;
  localparam int AW  = $clog2(FP);

  typedef struct {int val; int addr;} item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_frame = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          axiov;
  logic [7:0]    pixel;
  logic          busy;
  logic          frame_done;
  logic [7:0]    d1 = '0;
  logic [7:0]    d2 = '0;

  item_t exp_q[$];
  int    len_q[$];
  item_t cur;
  int    checks = 0;
  int    errors = 0;
  int    tick_no = 0;
  int    exp_start = -1;
  int    run_len = 0;
  int    low_len = 0;
  int    done_cnt = 0;
  int    prev_addr = 0;
  bit    in_frame = 1'b0;
  int    hist[0:BC];

  eth_pixel_feeder #(
    .FRAME_PIXELS(FP), .PIXELS_PER_PKT(PPP), .BYTE_CYCLES(BC),
    .RD_LATENCY(RDL), .IPG_CYCLES(IPG)
  ) dut (
    .clk(clk), .rst(rst), .start_frame(start_frame), .rd_addr(rd_addr),
    .rd_data(rd_data), .axiov(axiov), .pixel(pixel), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: two-clock read latency, contents addr+0x10
  always_ff @(posedge clk) begin
    d1 <= 8'(rd_addr) + 8'h10;
    d2 <= d1;
  end
  assign rd_data = d2;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (tick %0d)", tag, got, exp, tick_no);
    end
  endtask

  task automatic push_frame();
    int a = 0;
    int p = 0;
    while (a < FP) begin
      int n;
      n = (FP - a < PPP) ? FP - a : PPP;
      exp_q.push_back('{(p >> 8) & 255, -1});
      exp_q.push_back('{p & 255, -1});
      for (int k = 0; k < n; k++) exp_q.push_back('{(a + k + 16) & 255, a + k});
      len_q.push_back((2 + n) * BC);
      a += n;
      p++;
    end
  endtask

  task automatic sample();
    int l = -1;
    for (int i = BC; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(rd_addr);
    if (int'(rd_addr) != prev_addr) begin
      check("rd_seq", int'(rd_addr), (prev_addr + 1) % FP);
      prev_addr = int'(rd_addr);
    end
    if (axiov) begin
      if (run_len == 0 && in_frame) check("gap_len", low_len, IPG);
      if (run_len == 0 && !in_frame) begin
        check("start_time", tick_no, exp_start);
        check("busy_rise", int'(busy), 1);
      end
      if (run_len % BC == 0) begin
        check("q_avail", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        check("byte", int'(pixel), cur.val);
        if (cur.addr >= 0) check("rd_lead", hist[BC], cur.addr);
      end else begin
        check("hold", int'(pixel), cur.val);
      end
      run_len++;
      low_len = 0;
      in_frame = 1'b1;
    end else begin
      if (run_len != 0) begin
        check("len_avail", int'(len_q.size() != 0), 1);
        if (len_q.size() != 0) l = len_q.pop_front();
        check("pkt_len", run_len, l);
        run_len = 0;
      end
      low_len++;
      check("idle_pixel", int'(pixel), 0);
    end
    if (frame_done) begin
      check("done_gap", low_len, IPG + 1);
      check("busy_fall", int'(busy), 0);
      done_cnt++;
      in_frame = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tick_no++;
    sample();
  endtask

  task automatic pulse(input bit accept);
    if (accept) begin
      push_frame();
      exp_start = tick_no + 1;
    end
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      tick();
      n++;
    end
    check("done_cnt", done_cnt, target);
    check("q_drain", int'(exp_q.size()), 0);
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    while (cur.addr != a && n < 400) begin
      tick();
      n++;
    end
    check("reach_byte", cur.addr, a);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_axiov"}, int'(axiov), 0);
    check({tag, "_pixel"}, int'(pixel), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(frame_done), 0);
  endtask

  initial begin
    cur = '{0, -1};
    for (int i = 0; i <= BC; i++) hist[i] = 0;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b1;
    tick();
    tick();
    pulse(1'b1);
    wait_done(1);
    repeat (2) tick();
    pulse(1'b1);
    repeat (35) tick();
    pulse(1'b0);
    wait_done(2);
    repeat (3) tick();
    pulse(1'b1);
    wait_done(3);
    start_frame = 1'b1;
    tick();
    pulse(1'b1);
    wait_done(4);
    repeat (3) tick();
    pulse(1'b1);
    wait_addr(6);
    #1 rst = 1'b0;
    #1 check_reset("abort");
    exp_q.delete();
    len_q.delete();
    cur = '{0, -1};
    run_len = 0;
    low_len = 0;
    in_frame = 1'b0;
    prev_addr = 0;
    for (int i = 0; i <= BC; i++) hist[i] = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    pulse(1'b1);
    wait_done(5);
    repeat (20) tick();
    check("done_total", done_cnt, 5);
    check("q_final", int'(exp_q.size() + len_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
